// File: rtl/hazard_stall_if.sv
// Pipeline-side signal bundle for the hazard/stall unit: D/E/M hazard fields in,
// stall request, MULT/DIV busy flag and stall-cycle counter out.
interface hazard_stall_if #(
  parameter int unsigned PERF_W = 32
);
  logic [4:0]        d_rs;
  logic [4:0]        d_rt;
  logic [1:0]        d_tuse_rs;
  logic [1:0]        d_tuse_rt;
  logic              d_is_md;
  logic [4:0]        e_wa;
  logic [1:0]        e_tnew;
  logic [4:0]        m_wa;
  logic [1:0]        m_tnew;
  logic              e_md_start;
  logic              e_md_is_div;
  logic              stall;
  logic              md_busy;
  logic [PERF_W-1:0] stall_cnt;

  modport master (
    output d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
    output e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_is_div,
    input  stall, md_busy, stall_cnt
  );

  modport slave (
    input  d_rs, d_rt, d_tuse_rs, d_tuse_rt, d_is_md,
    input  e_wa, e_tnew, m_wa, m_tnew, e_md_start, e_md_is_div,
    output stall, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_unit.sv
// Hazard detection for the 5-stage MIPS pipeline: Tuse/Tnew data hazards, MULT/DIV busy
// tracking and a saturating stall-cycle counter.
module hazard_stall_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10,
  parameter int unsigned CNT_W       = 4,
  parameter int unsigned PERF_W      = 32
) (
  input logic           clk,
  input logic           reset,
  hazard_stall_if.slave hs
);

  localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] perf_q, perf_d;
  logic              rs_hazard, rt_hazard, md_hazard, busy, stall;

  always_comb begin
    busy = (cnt_q != '0);
    // A producer with tnew == 0 never stalls: forwarding delivers it in time.
    rs_hazard = (hs.d_rs != 5'd0) &&
                ((hs.e_wa == hs.d_rs && hs.e_tnew > hs.d_tuse_rs) ||
                 (hs.m_wa == hs.d_rs && hs.m_tnew > hs.d_tuse_rs));
    rt_hazard = (hs.d_rt != 5'd0) &&
                ((hs.e_wa == hs.d_rt && hs.e_tnew > hs.d_tuse_rt) ||
                 (hs.m_wa == hs.d_rt && hs.m_tnew > hs.d_tuse_rt));
    md_hazard = hs.d_is_md && (busy || hs.e_md_start);
    stall     = rs_hazard | rt_hazard | md_hazard;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (hs.e_md_start) begin
      cnt_d = hs.e_md_is_div ? DivLoad : MultLoad;
    end else if (busy) begin
      cnt_d = cnt_q - 1'b1;
    end
    perf_d = perf_q;
    if (stall && (perf_q != {PERF_W{1'b1}})) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      perf_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      perf_q <= perf_d;
    end
  end

  assign hs.stall     = stall;
  assign hs.md_busy   = busy;
  assign hs.stall_cnt = perf_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Bench for hazard_stall_unit: directed literal scenarios plus randomized traffic checked
// every cycle against a cycle-indexed behavioural model (32-bit and 3-bit counter instances).
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  hazard_stall_if #(.PERF_W(32)) hs ();
  hazard_stall_if #(.PERF_W(3))  hs3 ();

  assign hs3.d_rs        = hs.d_rs;
  assign hs3.d_rt        = hs.d_rt;
  assign hs3.d_tuse_rs   = hs.d_tuse_rs;
  assign hs3.d_tuse_rt   = hs.d_tuse_rt;
  assign hs3.d_is_md     = hs.d_is_md;
  assign hs3.e_wa        = hs.e_wa;
  assign hs3.e_tnew      = hs.e_tnew;
  assign hs3.m_wa        = hs.m_wa;
  assign hs3.m_tnew      = hs.m_tnew;
  assign hs3.e_md_start  = hs.e_md_start;
  assign hs3.e_md_is_div = hs.e_md_is_div;

  hazard_stall_unit #(.PERF_W(32)) dut (.clk(clk), .reset(reset), .hs(hs.slave));
  hazard_stall_unit #(.PERF_W(3))  dut3 (.clk(clk), .reset(reset), .hs(hs3.slave));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: busy while fewer than len edges have passed since the last start was accepted.
  int  cyc = 0;
  int  last_start = -1000;
  int  last_len = 0;
  int  perf = 0;
  bit  model_valid = 1'b0;

  function automatic bit m_busy();
    return (cyc - last_start) >= 1 && (cyc - last_start) <= last_len;
  endfunction

  function automatic bit hz(input logic [4:0] r, input logic [1:0] tuse);
    if (r == 5'd0) return 1'b0;
    if (hs.e_wa == r && int'(hs.e_tnew) > int'(tuse)) return 1'b1;
    if (hs.m_wa == r && int'(hs.m_tnew) > int'(tuse)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_stall();
    return hz(hs.d_rs, hs.d_tuse_rs) || hz(hs.d_rt, hs.d_tuse_rt) ||
           (hs.d_is_md && (m_busy() || hs.e_md_start));
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      last_start  = -1000;
      perf        = 0;
      model_valid = 1'b1;
    end else if (model_valid) begin
      if (m_stall()) perf = perf + 1;
      if (hs.e_md_start) begin
        last_start = cyc;
        last_len   = hs.e_md_is_div ? 10 : 5;
      end
    end
    cyc = cyc + 1;
  end

  always @(negedge clk) begin
    if (model_valid) begin
      chk("model_stall",     {31'd0, hs.stall},   {31'd0, m_stall()});
      chk("model_md_busy",   {31'd0, hs.md_busy}, {31'd0, m_busy()});
      chk("model_stall_cnt", hs.stall_cnt,        perf);
      chk("model_stall_cnt3", {29'd0, hs3.stall_cnt}, (perf > 7) ? 32'd7 : perf);
    end
  end

  task automatic idle();
    hs.d_rs = 5'd0; hs.d_rt = 5'd0; hs.d_tuse_rs = 2'd3; hs.d_tuse_rt = 2'd3;
    hs.d_is_md = 1'b0; hs.e_wa = 5'd0; hs.e_tnew = 2'd0; hs.m_wa = 5'd0; hs.m_tnew = 2'd0;
    hs.e_md_start = 1'b0; hs.e_md_is_div = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic md_run(input bit is_div, input bit is_md, input int n,
                        output int stalls, output int busys, output int run);
    stalls = 0; busys = 0; run = 0;
    idle();
    hs.e_md_start = 1'b1; hs.e_md_is_div = is_div; hs.d_is_md = is_md;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (hs.stall === 1'b1) begin
        stalls++;
        if (run == i) run++;
      end
      if (hs.md_busy === 1'b1) busys++;
      step();
      hs.e_md_start = 1'b0;
    end
  endtask

  initial begin
    int s, b, r;
    reset = 1'b1;
    idle();
    step(); step();
    reset = 1'b0;

    // Load-use then resolved from M.
    hs.e_wa = 5'd5; hs.e_tnew = 2'd2; hs.d_rs = 5'd5; hs.d_tuse_rs = 2'd1;
    @(negedge clk); chk("reset_md_busy", {31'd0, hs.md_busy}, 32'd0);
    chk("load_use_stall", {31'd0, hs.stall}, 32'd1);
    step();
    hs.e_wa = 5'd0; hs.m_wa = 5'd5; hs.m_tnew = 2'd1;
    @(negedge clk); chk("load_use_resolved", {31'd0, hs.stall}, 32'd0);
    step();

    // $0 and unused operand.
    idle(); hs.e_wa = 5'd0; hs.d_rs = 5'd0; hs.e_tnew = 2'd2;
    @(negedge clk); chk("reg0_no_stall", {31'd0, hs.stall}, 32'd0);
    hs.d_rt = 5'd7; hs.e_wa = 5'd7; hs.e_tnew = 2'd1; hs.d_tuse_rt = 2'd3;
    @(negedge clk); chk("no_use_no_stall", {31'd0, hs.stall}, 32'd0);
    hs.d_tuse_rt = 2'd0;
    @(negedge clk); chk("rt_hazard", {31'd0, hs.stall}, 32'd1);
    step();

    md_run(1'b0, 1'b1, 12, s, b, r);
    chk("mult_stall_cycles", s, 32'd6); chk("mult_stall_run", r, 32'd6);
    chk("mult_busy_cycles", b, 32'd5);
    md_run(1'b1, 1'b1, 14, s, b, r);
    chk("div_stall_cycles", s, 32'd11); chk("div_stall_run", r, 32'd11);
    md_run(1'b1, 1'b0, 14, s, b, r);
    chk("div_no_md_stall", s, 32'd0); chk("div_busy_cycles", b, 32'd10);

    // Reset three cycles into a divide.
    idle(); hs.e_md_start = 1'b1; hs.e_md_is_div = 1'b1;
    step(); idle(); step(); step();
    reset = 1'b1;
    step();
    @(negedge clk);
    chk("reset_abort_busy", {31'd0, hs.md_busy}, 32'd0);
    chk("reset_stall_cnt", hs.stall_cnt, 32'd0);
    chk("reset_stall_cnt3", {29'd0, hs3.stall_cnt}, 32'd0);
    step();
    reset = 1'b0;
    hs.e_wa = 5'd5; hs.e_tnew = 2'd2; hs.d_rs = 5'd5; hs.d_tuse_rs = 2'd1;
    repeat (4) step();
    idle();
    @(negedge clk);
    chk("stall_cnt_4", hs.stall_cnt, 32'd4);
    chk("stall_cnt3_4", {29'd0, hs3.stall_cnt}, 32'd4);
    hs.e_wa = 5'd5; hs.e_tnew = 2'd2; hs.d_rs = 5'd5; hs.d_tuse_rs = 2'd1;
    step();
    repeat (4) step();
    idle();
    @(negedge clk);
    chk("stall_cnt_9", hs.stall_cnt, 32'd9);
    chk("stall_cnt3_sat", {29'd0, hs3.stall_cnt}, 32'd7);
    step();

    // Randomized traffic; small register range makes matches frequent.
    for (int i = 0; i < 3000; i++) begin
      hs.d_rs        = 5'($urandom_range(0, 3));
      hs.d_rt        = 5'($urandom_range(0, 3));
      hs.d_tuse_rs   = 2'($urandom_range(0, 3));
      hs.d_tuse_rt   = 2'($urandom_range(0, 3));
      hs.d_is_md     = ($urandom_range(0, 3) == 0);
      hs.e_wa        = 5'($urandom_range(0, 3));
      hs.e_tnew      = 2'($urandom_range(0, 3));
      hs.m_wa        = 5'($urandom_range(0, 3));
      hs.m_tnew      = 2'($urandom_range(0, 3));
      hs.e_md_start  = ($urandom_range(0, 11) == 0);
      hs.e_md_is_div = 1'($urandom_range(0, 1));
      reset          = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 1'b0;
    idle();
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
